// File: rtl/lambda_peak_search.sv
// Windowed peak search over a lambda/theta sample stream: reports the index,
// value and paired theta of the largest lambda in each WIN_LEN-sample window.
module lambda_peak_search #(
  parameter int WIN_LEN = 256,
  parameter int IDX_W   = $clog2(WIN_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [13:0]  lambda_in,
  input  logic        [13:0]  theta_in,
  input  logic                valid_in,
  input  logic                frame_start,
  output logic [IDX_W-1:0]    peak_idx,
  output logic signed [13:0]  peak_lambda,
  output logic        [13:0]  peak_theta,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

  typedef enum logic {IDLE, SEARCH} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  state_t                    state_reg;
  logic [IDX_W-1:0]          cnt_reg;
  logic [IDX_W-1:0]          max_idx_reg;
  logic signed [13:0]        max_lambda_reg;
  logic        [13:0]        max_theta_reg;
  logic                      take_new;

  // Strictly greater only, so ties keep the earliest index.
  assign take_new = lambda_in > max_lambda_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      max_idx_reg    <= '0;
      max_lambda_reg <= '0;
      max_theta_reg  <= '0;
      peak_idx       <= '0;
      peak_lambda    <= '0;
      peak_theta     <= '0;
      out_valid      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (valid_in && frame_start) begin
        // Index 0 loads unconditionally; also aborts any window in progress.
        state_reg      <= SEARCH;
        cnt_reg        <= IDX_W'(1);
        max_idx_reg    <= '0;
        max_lambda_reg <= lambda_in;
        max_theta_reg  <= theta_in;
      end else if (valid_in && state_reg == SEARCH) begin
        if (take_new) begin
          max_idx_reg    <= cnt_reg;
          max_lambda_reg <= lambda_in;
          max_theta_reg  <= theta_in;
        end
        if (cnt_reg == LAST_IDX) begin
          // The last sample joins the compare directly on its way to the outputs.
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          peak_idx    <= take_new ? cnt_reg   : max_idx_reg;
          peak_lambda <= take_new ? lambda_in : max_lambda_reg;
          peak_theta  <= take_new ? theta_in  : max_theta_reg;
          out_valid   <= 1'b1;
          if (out_valid && !out_ready)
            overrun <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lambda_peak_search.sv
// Bench for lambda_peak_search with WIN_LEN=8: directed scenarios plus a
// randomized stream checked against a queue-based window model.
module tb_lambda_peak_search;

  localparam int WIN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] lambda_in = '0;
  logic [13:0] theta_in = '0;
  logic        valid_in = 1'b0;
  logic        frame_start = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  peak_idx;
  logic [13:0] peak_lambda;
  logic [13:0] peak_theta;
  logic        out_valid;
  logic        overrun;

  int total = 0;
  int bad = 0;

  lambda_peak_search #(.WIN_LEN(WIN)) dut (
    .clk(clk), .rst(rst), .lambda_in(lambda_in), .theta_in(theta_in),
    .valid_in(valid_in), .frame_start(frame_start), .peak_idx(peak_idx),
    .peak_lambda(peak_lambda), .peak_theta(peak_theta), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit v, input bit fs, input logic [13:0] l, input logic [13:0] t);
    valid_in = v; frame_start = fs; lambda_in = l; theta_in = t;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    total += 5;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    if (peak_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", peak_idx); end
    if (peak_lambda !== 14'd0) begin bad++; $display("FAIL reset_lambda got=%h want=0", peak_lambda); end
    if (peak_theta !== 14'd0) begin bad++; $display("FAIL reset_theta got=%h want=0", peak_theta); end
    @(posedge clk); #1 rst = 1'b0;
    $display("test_reset: outputs checked under reset");
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      drive(1'b1, i == 0, (i == 5) ? 14'h10 : 14'(i + 1), 14'(i * 256));
      if (i < WIN - 1) begin
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early idx=%0d got=%b want=0", i, out_valid); end
      end
    end
    total += 4;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
    if (peak_idx !== 3'd5) begin bad++; $display("FAIL basic_idx got=%0d want=5", peak_idx); end
    if (peak_lambda !== 14'h10) begin bad++; $display("FAIL basic_lambda got=%h want=0010", peak_lambda); end
    if (peak_theta !== 14'h500) begin bad++; $display("FAIL basic_theta got=%h want=0500", peak_theta); end
    drive(1'b0, 1'b0, '0, '0);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%b want=0", out_valid); end
    $display("test_basic: window done idx=%0d lambda=%h theta=%h", peak_idx, peak_lambda, peak_theta);
  endtask

  task automatic test_all_negative;
    for (int i = 0; i < WIN; i++)
      drive(1'b1, i == 0, (i == 0) ? 14'(-128) : 14'(-512), 14'(i + 3));
    total += 4;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL neg_valid got=%b want=1", out_valid); end
    if (peak_idx !== 3'd0) begin bad++; $display("FAIL neg_idx got=%0d want=0", peak_idx); end
    if (peak_lambda !== 14'(-128)) begin bad++; $display("FAIL neg_lambda got=%h want=%h", peak_lambda, 14'(-128)); end
    if (peak_theta !== 14'd3) begin bad++; $display("FAIL neg_theta got=%h want=0003", peak_theta); end
    $display("test_all_negative: window done idx=%0d lambda=%h", peak_idx, peak_lambda);
  endtask

  task automatic test_gaps;
    for (int i = 0; i < WIN; i++) begin
      if (i > 0) drive(1'b0, 1'b0, 14'h1FFF, 14'h3FFF);
      drive(1'b1, i == 0, (i == 2 || i == 6) ? 14'h300 : 14'h100, 14'(i));
    end
    total += 4;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL gaps_valid got=%b want=1", out_valid); end
    if (peak_idx !== 3'd2) begin bad++; $display("FAIL gaps_idx got=%0d want=2", peak_idx); end
    if (peak_lambda !== 14'h300) begin bad++; $display("FAIL gaps_lambda got=%h want=0300", peak_lambda); end
    if (peak_theta !== 14'd2) begin bad++; $display("FAIL gaps_theta got=%h want=0002", peak_theta); end
    $display("test_gaps: window done idx=%0d lambda=%h", peak_idx, peak_lambda);
  endtask

  task automatic test_back_to_back;
    drive(1'b0, 1'b0, '0, '0);
    out_ready = 1'b0;
    for (int i = 0; i < WIN; i++) drive(1'b1, i == 0, 14'(i), 14'(i));
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got=%b want=1", out_valid); end
    if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_first_overrun got=%b want=0", overrun); end
    if (peak_idx !== 3'd7) begin bad++; $display("FAIL b2b_first_idx got=%0d want=7", peak_idx); end
    for (int i = 0; i < WIN; i++) drive(1'b1, i == 0, 14'(8 - i), 14'(i + 16));
    total += 5;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%b want=1", out_valid); end
    if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%b want=1", overrun); end
    if (peak_idx !== 3'd0) begin bad++; $display("FAIL b2b_second_idx got=%0d want=0", peak_idx); end
    if (peak_lambda !== 14'd8) begin bad++; $display("FAIL b2b_second_lambda got=%h want=0008", peak_lambda); end
    if (peak_theta !== 14'd16) begin bad++; $display("FAIL b2b_second_theta got=%h want=0010", peak_theta); end
    out_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    total += 2;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain_valid got=%b want=0", out_valid); end
    if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_sticky_overrun got=%b want=1", overrun); end
    $display("test_back_to_back: two windows done overrun=%b", overrun);
  endtask

  task automatic test_abort;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 14'h1000, 14'h2AA);
    for (int i = 0; i < WIN; i++) begin
      drive(1'b1, i == 0, (i == 3) ? 14'h50 : 14'(i), 14'(i + 32));
      if (i < WIN - 1) begin
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_spurious idx=%0d got=%b want=0", i, out_valid); end
      end
    end
    total += 4;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL abort_valid got=%b want=1", out_valid); end
    if (peak_idx !== 3'd3) begin bad++; $display("FAIL abort_idx got=%0d want=3", peak_idx); end
    if (peak_lambda !== 14'h50) begin bad++; $display("FAIL abort_lambda got=%h want=0050", peak_lambda); end
    if (peak_theta !== 14'd35) begin bad++; $display("FAIL abort_theta got=%h want=0023", peak_theta); end
    $display("test_abort: new window done idx=%0d", peak_idx);
  endtask

  task automatic test_reset_midwindow;
    for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 14'h200, 14'h11);
    valid_in = 1'b1; lambda_in = 14'h7FF;
    rst = 1'b1;
    #1;
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_async_valid got=%b want=0", out_valid); end
    if (overrun !== 1'b0) begin bad++; $display("FAIL midrst_async_overrun got=%b want=0", overrun); end
    if (peak_lambda !== 14'd0) begin bad++; $display("FAIL midrst_async_lambda got=%h want=0", peak_lambda); end
    if (peak_idx !== 3'd0) begin bad++; $display("FAIL midrst_async_idx got=%0d want=0", peak_idx); end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < WIN; i++) begin
      drive(1'b1, 1'b0, 14'(100 + i), 14'(i + 1));
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid cyc=%0d got=%b want=0", i, out_valid); end
    end
    drive(1'b0, 1'b0, '0, '0);
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_tail_valid got=%b want=0", out_valid); end
    if (peak_lambda !== 14'd0) begin bad++; $display("FAIL midrst_lambda got=%h want=0", peak_lambda); end
    if (peak_theta !== 14'd0) begin bad++; $display("FAIL midrst_theta got=%h want=0", peak_theta); end
    $display("test_reset_midwindow: partial window discarded");
  endtask

  // Random stream with gaps, aborts and back-pressure against a window model.
  task automatic test_random;
    logic [13:0] wl[$];
    logic [13:0] wt[$];
    bit active = 0;
    bit exp_valid = 0;
    bit exp_ovr = 0;
    int exp_idx = 0;
    logic [13:0] exp_l = '0;
    logic [13:0] exp_t = '0;
    int nres = 0;
    for (int c = 0; c < 600; c++) begin
      bit v, fs, rdy, new_res;
      logic [13:0] l, t;
      v = ($urandom_range(0, 3) != 0);
      fs = v && (active ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0));
      if (active && wl.size() == WIN - 1) fs = 0;
      l = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 15)) - 14'd8 : 14'($urandom);
      t = 14'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      new_res = 0;
      if (v && fs) begin
        wl = {l}; wt = {t}; active = 1;
      end else if (v && active) begin
        wl.push_back(l); wt.push_back(t);
        if (wl.size() == WIN) begin
          new_res = 1; active = 0; exp_idx = 0;
          for (int k = 1; k < WIN; k++)
            if ($signed(wl[k]) > $signed(wl[exp_idx])) exp_idx = k;
          exp_l = wl[exp_idx]; exp_t = wt[exp_idx];
          wl.delete(); wt.delete();
        end
      end
      if (new_res) begin
        if (exp_valid && !rdy) exp_ovr = 1;
        exp_valid = 1;
        nres++;
      end else if (exp_valid && rdy) begin
        exp_valid = 0;
      end
      out_ready = rdy;
      drive(v, fs, l, t);
      total += 2;
      if (out_valid !== exp_valid) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, out_valid, exp_valid); end
      if (overrun !== exp_ovr) begin bad++; $display("FAIL rand_overrun cyc=%0d got=%b want=%b", c, overrun, exp_ovr); end
      if (exp_valid) begin
        total += 3;
        if (peak_idx !== 3'(exp_idx)) begin bad++; $display("FAIL rand_idx cyc=%0d got=%0d want=%0d", c, peak_idx, exp_idx); end
        if (peak_lambda !== exp_l) begin bad++; $display("FAIL rand_lambda cyc=%0d got=%h want=%h", c, peak_lambda, exp_l); end
        if (peak_theta !== exp_t) begin bad++; $display("FAIL rand_theta cyc=%0d got=%h want=%h", c, peak_theta, exp_t); end
      end
    end
    out_ready = 1'b1;
    $display("test_random: %0d windows completed", nres);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_all_negative;
    test_gaps;
    test_back_to_back;
    test_abort;
    test_reset_midwindow;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lambda_peak_search.md
LAMBDA_PEAK_SEARCH -- requirements
Module: lambda_peak_search

Interface
REQ-001 SHALL provide parameter WIN_LEN, default 256, meaning the number of lambda samples per search window (legal 2..4096).
REQ-002 SHALL provide parameter IDX_W, default $clog2(WIN_LEN), meaning the width of the peak index.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 lambda_in  input  14  signed Q6.8 log-likelihood metric, lambda_t.
REQ-007 theta_in  input  14  signed Q6.8 phase angle paired with lambda_in, same cycle.
REQ-008 valid_in  input  1  lambda_in/theta_in carry a sample this cycle.
REQ-009 frame_start  input  1  pulse marking the current valid sample as window index 0; ignored without valid_in.
REQ-010 peak_idx  output  IDX_W  window index of the maximum lambda.
REQ-011 peak_lambda  output  14  maximum lambda value, signed Q6.8.
REQ-012 peak_theta  output  14  theta_in captured with the maximum sample.
REQ-013 out_valid  output  1  result registers hold an unconsumed result.
REQ-014 out_ready  input  1  consumer accepts the result when high together with out_valid.
REQ-015 overrun  output  1  sticky flag: a result was overwritten before it was accepted.

Function
REQ-016 SHALL implement FSM states IDLE and SEARCH.
- IDLE -> SEARCH on valid_in&frame_start.
- SEARCH -> IDLE after the sample with index WIN_LEN-1 is accepted.
REQ-017 In IDLE, valid samples without frame_start SHALL be discarded.
REQ-018 The sample at index 0 SHALL load the running max unconditionally, so an all-negative window still reports a correct peak.
REQ-019 A later sample SHALL replace the running max only if strictly greater in signed compare.
- Ties keep the earliest index.
REQ-020 The sample counter SHALL advance only on valid_in; gaps in valid_in SHALL not affect indices.
REQ-021 On acceptance of index WIN_LEN-1, the result SHALL be registered to the peak_* outputs and out_valid SHALL assert the next cycle.
- Latency: 1 cycle from last sample to out_valid.
- The last sample itself SHALL take part in the compare.
REQ-022 The peak_* outputs SHALL stay stable while out_valid=1 and out_ready=0, until a new result overwrites them.
REQ-023 out_valid SHALL clear the cycle after out_valid&out_ready, unless a new result is registered in that same cycle, in which case out_valid SHALL stay 1 with the new values.
REQ-024 If a new result is registered while out_valid=1 and out_ready=0:
- the new result SHALL overwrite the old one;
- overrun SHALL set and hold until reset.
REQ-025 frame_start&valid_in in SEARCH SHALL abort the current window:
- no result for the aborted window;
- that sample becomes index 0 of a new window.
REQ-026 frame_start&valid_in on the same cycle as index WIN_LEN-1 is not possible; frame_start on the cycle following the last sample SHALL start a new window with no dead cycle.
REQ-027 The block SHALL never stall upstream; it has no ready output.

Reset
REQ-028 On rst=1, asynchronously and without waiting for a clock edge:
- FSM SHALL go to IDLE;
- counter and running max SHALL clear;
- peak_idx, peak_lambda, peak_theta SHALL be 0;
- out_valid and overrun SHALL be 0.
REQ-029 Reset mid-window SHALL discard the partial window; operation resumes only on the next frame_start.

Verification (WIN_LEN=8)
REQ-030 Lambda 1..8 with 0x10 (16) at index 5, theta=index*0x100, out_ready=1 -> one cycle after index 7: out_valid=1, peak_idx=5, peak_lambda=0x10, peak_theta=0x500, for exactly 1 cycle.
REQ-031 All lambda = -0x200 except -0x080 at index 0 -> peak_idx=0, peak_lambda=-0x080 (tests the unconditional load).
REQ-032 Equal max 0x300 at indices 2 and 6, with valid_in low every other cycle -> peak_idx=2; indices are unaffected by the gaps.
REQ-033 out_ready=0, two full windows back-to-back -> second result visible, overrun=1; out_ready=1 -> out_valid drops, overrun stays 1.
REQ-034 frame_start at index 4 of window A, then 8 samples -> single result for the new window only; peak_idx is relative to the new start.
REQ-035 rst asserted at index 3, then released, 8 samples with no frame_start -> no out_valid; outputs remain 0.
